// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive buffer that sits directly behind the UART receiver. Each rx_done
// assertion (rising edge only) pushes rx_data into a show-ahead FIFO. The head
// word is offered to the consumer over a valid/ready handshake. Words that
// arrive while the FIFO is full are dropped. A drop sets a sticky overrun flag
// and increments a saturating drop counter.
//
// Ports
//   clk          in   rising-edge system clock
//   reset        in   asynchronous active-low reset
//   rx_data      in   received word, sampled on the rx_done rising edge
//   rx_done      in   frame-complete strobe (any length)
//   rd_ready     in   consumer takes rd_data this cycle
//   clr_overrun  in   clears overrun and drop_count
//   rd_data      out  head-of-FIFO word (valid while rd_valid)
//   rd_valid     out  FIFO non-empty
//   count        out  occupancy 0..DEPTH
//   full         out  count == DEPTH
//   almost_full  out  count >= AFULL_LEVEL
//   overrun      out  sticky: a word has been dropped
//   drop_count   out  saturating count of dropped words
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int DATA_BIT    = 8,
  parameter int ADDR_BITS   = 4,
  parameter int DEPTH       = 2**ADDR_BITS,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BIT-1:0]  rx_data,
  input  logic                 rx_done,
  input  logic                 rd_ready,
  input  logic                 clr_overrun,
  output logic [DATA_BIT-1:0]  rd_data,
  output logic                 rd_valid,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overrun,
  output logic [7:0]           drop_count
);

  localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(DEPTH);
  localparam logic [ADDR_BITS:0] AFULL_C = (ADDR_BITS+1)'(AFULL_LEVEL);

  logic [DATA_BIT-1:0]  mem_q [DEPTH];
  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 rx_done_q;
  logic                 overrun_q, overrun_d;
  logic [7:0]           drop_count_q, drop_count_d;

  logic wr_evt, pop, wr_ok, drop;

  // One write per rx_done assertion regardless of how long it stays high.
  assign wr_evt = rx_done & ~rx_done_q;
  assign pop    = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign wr_ok  = wr_evt & (~full | pop);
  assign drop   = wr_evt & full & ~pop;

  assign rd_valid    = (count_q != '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AFULL_C);
  assign count       = count_q;
  assign rd_data     = mem_q[rd_ptr_q];
  assign overrun     = overrun_q;
  assign drop_count  = drop_count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // A drop coinciding with a clear wins: the new drop is still reported.
  always_comb begin
    overrun_d    = overrun_q;
    drop_count_d = drop_count_q;
    if (drop) begin
      overrun_d = 1'b1;
      if (clr_overrun)
        drop_count_d = 8'd1;
      else if (drop_count_q != 8'hFF)
        drop_count_d = drop_count_q + 8'd1;
    end else if (clr_overrun) begin
      overrun_d    = 1'b0;
      drop_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rx_done_q    <= 1'b0;
      overrun_q    <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rx_done_q    <= rx_done;
      overrun_q    <= overrun_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       rd_ready;
  logic       clr_overrun;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic       full;
  logic       almost_full;
  logic       overrun;
  logic [7:0] drop_count;

  int checks   = 0;
  int failures = 0;

  uart_rx_fifo #(
    .DATA_BIT   (8),
    .ADDR_BITS  (4),
    .AFULL_LEVEL(12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .rd_ready   (rd_ready),
    .clr_overrun(clr_overrun),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .count      (count),
    .full       (full),
    .almost_full(almost_full),
    .overrun    (overrun),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    tick();
  endtask

  task automatic pop_one();
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0; rx_done = 1'b0; rx_data = '0; rd_ready = 1'b0; clr_overrun = 1'b0;
    tick(); tick();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
    checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin failures++; $display("FAIL reset_flags got full=%b af=%b exp=0,0", full, almost_full); end
    checks++; if (overrun !== 1'b0 || drop_count !== 8'd0) begin failures++; $display("FAIL reset_ovr got ovr=%b drop=%0d exp=0,0", overrun, drop_count); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    rx_data = 8'hA5; rx_done = 1'b1;
    tick();
    rx_done = 1'b0;
    checks++; if (count !== 5'd1) begin failures++; $display("FAIL basic_count got=%0d exp=1", count); end
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin failures++; $display("FAIL basic_data got v=%b d=%h exp=1,a5", rd_valid, rd_data); end
    tick();
    pop_one();
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0) begin failures++; $display("FAIL basic_pop got cnt=%0d v=%b exp=0,0", count, rd_valid); end
    // rd_ready while empty must not underflow.
    pop_one();
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL empty_pop got=%0d exp=0", count); end
  endtask

  task automatic test_multicycle();
    rx_data = 8'h3C; rx_done = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    rx_done = 1'b0;
    tick();
    checks++; if (count !== 5'd1 || rd_data !== 8'h3C) begin failures++; $display("FAIL multi_cycle got cnt=%0d d=%h exp=1,3c", count, rd_data); end
    pop_one();
    // Empty FIFO: write and rd_ready together performs no pop.
    rx_data = 8'h77; rx_done = 1'b1; rd_ready = 1'b1;
    tick();
    rx_done = 1'b0; rd_ready = 1'b0;
    checks++; if (count !== 5'd1 || rd_data !== 8'h77) begin failures++; $display("FAIL empty_wr_rd got cnt=%0d d=%h exp=1,77", count, rd_data); end
    tick();
    pop_one();
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i < 16; i++) begin
      wr_word(8'(i));
      if (i == 10) begin
        checks++; if (almost_full !== 1'b0) begin failures++; $display("FAIL af_at11 got=%b exp=0", almost_full); end
      end
      if (i == 11) begin
        checks++; if (almost_full !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL af_at12 got af=%b full=%b exp=1,0", almost_full, full); end
      end
    end
    checks++; if (full !== 1'b1 || count !== 5'd16) begin failures++; $display("FAIL fill_full got full=%b cnt=%0d exp=1,16", full, count); end
    wr_word(8'h10);
    wr_word(8'h11);
    checks++; if (overrun !== 1'b1 || drop_count !== 8'd2 || count !== 5'd16) begin failures++; $display("FAIL overrun got ovr=%b drop=%0d cnt=%0d exp=1,2,16", overrun, drop_count, count); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin failures++; $display("FAIL drain_%0d got v=%b d=%h exp=1,%h", i, rd_valid, rd_data, 8'(i)); end
      pop_one();
    end
    checks++; if (rd_valid !== 1'b0 || count !== 5'd0) begin failures++; $display("FAIL drain_empty got v=%b cnt=%0d exp=0,0", rd_valid, count); end
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 16; i++) wr_word(8'h20 + 8'(i));
    checks++; if (rd_data !== 8'h20) begin failures++; $display("FAIL fp_head got=%h exp=20", rd_data); end
    rx_data = 8'h55; rx_done = 1'b1; rd_ready = 1'b1;
    tick();
    rx_done = 1'b0; rd_ready = 1'b0;
    checks++; if (count !== 5'd16 || overrun !== 1'b0) begin failures++; $display("FAIL fp_count got cnt=%0d ovr=%b exp=16,0", count, overrun); end
    tick();
    for (int i = 0; i < 16; i++) begin
      logic [7:0] exp_d;
      exp_d = (i == 15) ? 8'h55 : 8'h21 + 8'(i);
      checks++; if (rd_data !== exp_d) begin failures++; $display("FAIL fp_drain_%0d got=%h exp=%h", i, rd_data, exp_d); end
      pop_one();
    end
    checks++; if (count !== 5'd0) begin failures++; $display("FAIL fp_empty got=%0d exp=0", count); end
  endtask

  task automatic test_clear_collision();
    for (int i = 0; i < 16; i++) wr_word(8'h40 + 8'(i));
    for (int i = 0; i < 7; i++) wr_word(8'hEE);
    checks++; if (overrun !== 1'b1 || drop_count !== 8'd7) begin failures++; $display("FAIL coll_pre got ovr=%b drop=%0d exp=1,7", overrun, drop_count); end
    rx_data = 8'hEE; rx_done = 1'b1; clr_overrun = 1'b1;
    tick();
    rx_done = 1'b0; clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b1 || drop_count !== 8'd1) begin failures++; $display("FAIL coll_set got ovr=%b drop=%0d exp=1,1", overrun, drop_count); end
    checks++; if (count !== 5'd16 || rd_data !== 8'h40) begin failures++; $display("FAIL coll_fifo got cnt=%0d d=%h exp=16,40", count, rd_data); end
    tick();
    clr_overrun = 1'b1; tick(); clr_overrun = 1'b0;
    checks++; if (overrun !== 1'b0 || drop_count !== 8'd0) begin failures++; $display("FAIL coll_clr got ovr=%b drop=%0d exp=0,0", overrun, drop_count); end
  endtask

  task automatic test_saturation();
    // FIFO is still full from the previous scenario.
    for (int i = 0; i < 260; i++) wr_word(8'hCC);
    checks++; if (drop_count !== 8'd255 || overrun !== 1'b1) begin failures++; $display("FAIL sat got drop=%0d ovr=%b exp=255,1", drop_count, overrun); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 16; i++) wr_word(8'h60 + 8'(i));
    wr_word(8'hFF);
    wr_word(8'hFF);
    for (int i = 0; i < 7; i++) pop_one();
    tick();
    checks++; if (count !== 5'd9 || overrun !== 1'b1 || drop_count !== 8'd2) begin failures++; $display("FAIL ar_pre got cnt=%0d ovr=%b drop=%0d exp=9,1,2", count, overrun, drop_count); end
    #2 reset = 1'b0;
    #1;
    checks++; if (count !== 5'd0 || rd_valid !== 1'b0 || overrun !== 1'b0 || drop_count !== 8'd0) begin failures++; $display("FAIL ar_async got cnt=%0d v=%b ovr=%b drop=%0d exp=0,0,0,0", count, rd_valid, overrun, drop_count); end
    tick();
    reset = 1'b1;
    tick();
    wr_word(8'h9E);
    checks++; if (count !== 5'd1 || rd_data !== 8'h9E) begin failures++; $display("FAIL ar_after got cnt=%0d d=%h exp=1,9e", count, rd_data); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_multicycle();
    test_fill_overrun();
    test_full_pop();
    test_clear_collision();
    test_saturation();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
